// File: rtl/key_run_ctrl.sv
// Key/switch driven CPU clock-enable generator: single-step on KEY[0], free-run at a
// switch-selected rate. Optional hold-to-repeat stepping is enabled by defining KEY_REPEAT_EN.
module key_run_ctrl #(
  parameter int unsigned DIV_W    = 24,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned HOLD_CYC = 40000000,
  parameter int unsigned REP_CYC  = 5000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       KEY,
  input  logic [9:0]       SW,
  output logic             CPU_EN,
  output logic             RUN,
  output logic [CNT_W-1:0] STEP_CNT
);

  typedef enum logic [1:0] {StArm, StStep, StRun} state_e;

  state_e             state_q, state_d;
  logic [1:0]         key_q;
  logic [1:0]         press;
  logic [DIV_W-1:0]   div_q, div_d, rate_mask;
  logic               en_q, en_d;
  logic               run_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               halt;
  logic               rep_pulse;
  logic               unused_sw;

  assign press     = key_q & ~KEY;
  assign halt      = SW[0];
  assign unused_sw = ^SW[7:1];

  always_comb begin
    rate_mask = '0;
    unique case (SW[9:8])
      2'b00: rate_mask = '0;
      2'b01: rate_mask = {{(DIV_W-8){1'b0}}, 8'hFF};
      2'b10: rate_mask = {{(DIV_W-16){1'b0}}, 16'hFFFF};
      2'b11: rate_mask = '1;
      default: rate_mask = '0;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned HW = $clog2(HOLD_CYC + 1);

  logic [HW-1:0] hcnt_q, hcnt_inc;
  logic          hold_on_q, hold_go;

  // Holding continues only while stepping is legal and the step key stays down.
  assign hold_go   = (state_q == StStep) && !press[1] && !halt && !KEY[0];
  assign hcnt_inc  = hcnt_q + 1'b1;
  assign rep_pulse = hold_go && !press[0] && hold_on_q && (hcnt_inc == HW'(HOLD_CYC));

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_on_q <= 1'b0;
      hcnt_q    <= '0;
    end else if (hold_go && press[0]) begin
      hold_on_q <= 1'b1;
      hcnt_q    <= '0;
    end else if (hold_go && hold_on_q) begin
      // Reload so the next repeat lands exactly REP_CYC cycles later.
      hcnt_q <= rep_pulse ? HW'(HOLD_CYC - REP_CYC) : hcnt_inc;
    end else begin
      hold_on_q <= 1'b0;
      hcnt_q    <= '0;
    end
  end
`else
  assign rep_pulse = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 1'b1;
    en_d    = 1'b0;
    unique case (state_q)
      StArm: begin
        if (KEY == 2'b11) state_d = StStep;
      end
      StStep: begin
        if (press[1]) begin
          state_d = StRun;
          div_d   = '0;
        end else if (press[0] && !halt) begin
          en_d = 1'b1;
        end
      end
      StRun: begin
        if (press[1]) state_d = StStep;
        else if (!halt && ((div_d & rate_mask) == rate_mask)) en_d = 1'b1;
      end
      default: state_d = StArm;
    endcase
    en_d = en_d | rep_pulse;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StArm;
      key_q   <= 2'b00;
      div_q   <= '0;
      en_q    <= 1'b0;
      run_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= KEY;
      div_q   <= div_d;
      en_q    <= en_d;
      run_q   <= (state_d == StRun);
      cnt_q   <= cnt_q + CNT_W'(en_d);
    end
  end

  assign CPU_EN   = en_q;
  assign RUN      = run_q;
  assign STEP_CNT = cnt_q;

endmodule

// File: tb/tb_key_run_ctrl.sv
// Self-checking bench for key_run_ctrl: fixed vector table, directed corner sequences and a
// randomized run compared against a behavioural model.
module tb_key_run_ctrl;

  localparam int unsigned DIV_W = 24;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned HOLD  = 20;
  localparam int unsigned REP   = 5;
  localparam longint      PMOD  = 64'd1 << DIV_W;
  localparam longint      CMOD  = 64'd1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       key;
  logic [9:0]       sw;
  logic             cpu_en, run;
  logic [CNT_W-1:0] step_cnt;

  int errors   = 0;
  int n_checks = 0;

  // Behavioural model state: 0 = ARM, 1 = STEP, 2 = RUN.
  int         m_state;
  logic [1:0] m_keyd;
  longint     m_presc;
  longint     m_cnt;
  logic       m_en, m_run;
  int         m_age;

  key_run_ctrl #(
    .DIV_W   (DIV_W),
    .CNT_W   (CNT_W),
    .HOLD_CYC(HOLD),
    .REP_CYC (REP)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .KEY     (key),
    .SW      (sw),
    .CPU_EN  (cpu_en),
    .RUN     (run),
    .STEP_CNT(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic p0, p1, halt, en;
    int nstate, k;
    longint npresc, span;
    if (rst) begin
      m_state = 0; m_keyd = 2'b00; m_presc = 0; m_cnt = 0; m_en = 0; m_run = 0; m_age = -1;
    end else begin
      p0 = m_keyd[0] & ~key[0];
      p1 = m_keyd[1] & ~key[1];
      halt = sw[0];
      case (sw[9:8])
        2'b00: k = 0;
        2'b01: k = 8;
        2'b10: k = 16;
        default: k = DIV_W;
      endcase
      span = 64'd1 << k;
      nstate = m_state;
      npresc = (m_presc + 1) % PMOD;
      en = 1'b0;
      if (m_state == 0) begin
        if (key == 2'b11) nstate = 1;
      end else if (m_state == 1) begin
        if (p1) begin
          nstate = 2;
          npresc = 0;
        end else if (p0 && !halt) en = 1'b1;
      end else begin
        if (p1) nstate = 1;
        else if (!halt && (npresc % span) == span - 1) en = 1'b1;
      end
`ifdef KEY_REPEAT_EN
      if (m_state == 1 && !p1 && !halt && !key[0]) begin
        if (p0) m_age = 0;
        else if (m_age >= 0) begin
          m_age++;
          if (m_age >= HOLD && (m_age - HOLD) % REP == 0) en = 1'b1;
        end
      end else m_age = -1;
`endif
      m_cnt   = (m_cnt + en) % CMOD;
      m_keyd  = key;
      m_state = nstate;
      m_presc = npresc;
      m_en    = en;
      m_run   = (nstate == 2);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_chk();
    chk("model_cpu_en", cpu_en, m_en);
    chk("model_run", run, m_run);
    chk("model_step_cnt", step_cnt, m_cnt);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  key;
    logic [9:0]  sw;
    logic        en;
    logic        run;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[22];

  initial begin
    int first, pulses, bad, low, wraps;
    longint saved;
    logic [CNT_W-1:0] prev;

    // {rst, key, sw} applied before an edge, {cpu_en, run, step_cnt} expected after it.
    vecs[0]  = '{1'b1, 2'b00, 10'h000, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 2'b00, 10'h000, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 2'b00, 10'h000, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 2'b01, 10'h000, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 2'b10, 10'h000, 1'b0, 1'b0, 16'd0}; // press in ARM ignored
    vecs[5]  = '{1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 2'b10, 10'h000, 1'b1, 1'b0, 16'd1};
    vecs[8]  = '{1'b0, 2'b10, 10'h000, 1'b0, 1'b0, 16'd1};
    vecs[9]  = '{1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 16'd1};
    vecs[10] = '{1'b0, 2'b01, 10'h000, 1'b0, 1'b1, 16'd1};
    vecs[11] = '{1'b0, 2'b11, 10'h000, 1'b1, 1'b1, 16'd2};
    vecs[12] = '{1'b0, 2'b11, 10'h000, 1'b1, 1'b1, 16'd3};
    vecs[13] = '{1'b0, 2'b01, 10'h000, 1'b0, 1'b0, 16'd3};
    vecs[14] = '{1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 16'd3};
    vecs[15] = '{1'b0, 2'b10, 10'h001, 1'b0, 1'b0, 16'd3}; // halted press discarded
    vecs[16] = '{1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 16'd3};
    vecs[17] = '{1'b0, 2'b00, 10'h000, 1'b0, 1'b1, 16'd3}; // both pressed: toggle wins
    vecs[18] = '{1'b0, 2'b11, 10'h000, 1'b1, 1'b1, 16'd4};
    vecs[19] = '{1'b1, 2'b11, 10'h000, 1'b0, 1'b0, 16'd0};
    vecs[20] = '{1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 16'd0};
    vecs[21] = '{1'b0, 2'b01, 10'h000, 1'b0, 1'b1, 16'd0};

    rst = 1'b1; key = 2'b00; sw = '0;
    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst; key = vecs[i].key; sw = vecs[i].sw;
      tick();
      chk($sformatf("vec%0d_cpu_en", i), cpu_en, vecs[i].en);
      chk($sformatf("vec%0d_run", i), run, vecs[i].run);
      chk($sformatf("vec%0d_step_cnt", i), step_cnt, vecs[i].cnt);
    end

    // Back to STEP, then toggle into RUN at rate 01 with stray step presses.
    key = 2'b11; tick();
    key = 2'b01; tick();
    key = 2'b11; tick();
    chk("to_step_run", run, 0);
    sw = 10'h100; key = 2'b01; tick();
    chk("rate256_run", run, 1);
    first = 0; pulses = 0; bad = 0;
    for (int c = 1; c <= 600; c++) begin
      key = (c == 100 || c == 300) ? 2'b10 : 2'b11;
      tick();
      if (cpu_en != ((c + 1) % 256 == 0)) bad++;
      if (cpu_en) begin
        pulses++;
        if (first == 0) first = c + 1;
      end
    end
    chk("rate256_bad_cycles", bad, 0);
    chk("rate256_first_cycle", first, 256);
    chk("rate256_pulses", pulses, 2);

    // Every-cycle rate long enough to wrap the step counter.
    sw = 10'h000; key = 2'b11; low = 0; wraps = 0;
    tick();
    prev = step_cnt;
    for (int c = 0; c < 70000; c++) begin
      tick();
      if (!cpu_en) low++;
      if (step_cnt == 0 && prev == '1) wraps++;
      prev = step_cnt;
    end
    chk("rate1_low_cycles", low, 0);
    chk("rate1_wraps", wraps, 1);
    chk("rate1_step_cnt", step_cnt, m_cnt);

    // Halt in STEP: presses discarded, then a normal press after release of halt.
    key = 2'b01; tick();
    key = 2'b11; tick();
    saved = m_cnt; sw = 10'h001; pulses = 0;
    for (int p = 0; p < 3; p++) begin
      key = 2'b10; tick(); pulses += cpu_en;
      key = 2'b11; tick(); pulses += cpu_en;
    end
    chk("halt_pulses", pulses, 0);
    chk("halt_step_cnt", step_cnt, saved);
    sw = 10'h000; tick();
    key = 2'b10; tick();
    chk("post_halt_pulse", cpu_en, 1);
    chk("post_halt_step_cnt", step_cnt, (saved + 1) % CMOD);
    key = 2'b11; tick();

`ifdef KEY_REPEAT_EN
    bad = 0; pulses = 0;
    for (int j = 1; j <= 60; j++) begin
      key = (j <= 40) ? 2'b10 : 2'b11;
      tick();
      if (cpu_en) pulses++;
      if (cpu_en != (j == 1 || j == 21 || j == 26 || j == 31 || j == 36)) bad++;
    end
    chk("repeat_bad_cycles", bad, 0);
    chk("repeat_pulses", pulses, 5);
`endif

    // Randomized run against the model.
    for (int c = 0; c < 6000; c++) begin
      rst = ($urandom % 500) == 0;
      if (($urandom % 8) == 0) key[0] = ~key[0];
      if (($urandom % 12) == 0) key[1] = ~key[1];
      if (($urandom % 40) == 0) sw[0] = ($urandom % 4) == 0;
      if (($urandom % 300) == 0) sw[9:8] = ($urandom % 4 == 0) ? 2'b10 : 2'($urandom % 2);
      if (($urandom % 20) == 0) sw[7:1] = 7'($urandom);
      tick();
      model_chk();
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
